// File: rtl/dmem_bus_responder.sv
// MEM-stage load/store responder: drives a registered req/ack data bus and
// stalls the pipeline until the access completes, aborts on timeout or flags an error.
module dmem_bus_responder #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          mem_err_q, mem_err_d;
    logic          start;
    logic          bad_req;

    assign start   = mem_valid & (mem_ren ^ mem_wen) & (mem_addr[1:0] == 2'b00);
    // Any valid request that cannot start is illegal: both ren&wen, or misaligned.
    assign bad_req = mem_valid & (mem_ren | mem_wen) & ~start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_rdata_d = mem_rdata_q;
        mem_err_d   = mem_err_q;
        mem_stall   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_stall   = 1'b1;
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wen;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_wdata_d = mem_wdata;
                end else if (bad_req) begin
                    mem_err_d = 1'b1;
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        if (rst) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mem_rdata_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: directed and random accesses checked against an
// access-level model (stall length, bus beats, sticky error, load data).
module tb_dmem_bus_responder;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;
    int          req_rises = 0;
    logic        req_prev  = 1'b0;

    dmem_bus_responder #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_req && !req_prev) req_rises++;
        req_prev = bus_req;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // One pipeline access: request held while stalled, bus answered k REQ cycles
    // after bus_req rises (k<0: never). Model computed from the access rules.
    task automatic run_access(input logic valid, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int k, input logic [31:0] rd, input logic hold);
        logic good, bad_req, acked;
        int   exp_stall, exp_reqs, stalls, reqs;
        bit   done;
        good      = valid && (ren ^ wen) && (addr[1:0] == 2'b00);
        bad_req   = valid && (ren || wen) && !good;
        acked     = good && (k >= 0) && (k < TIMEOUT);
        exp_stall = !good ? 0 : (acked ? k + 2 : TIMEOUT + 1);
        exp_reqs  = !good ? 0 : (acked ? k + 1 : TIMEOUT);

        @(negedge clk);
        mem_valid = valid; mem_ren = ren; mem_wen = wen;
        mem_addr  = addr;  mem_wdata = wdata;
        stalls = 0; reqs = 0; done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            bus_ack = 1'b0;
            if (bus_req) begin
                total++;
                if (bus_we !== wen) begin
                    bad++; $display("FAIL bus_we: got %0b want %0b", bus_we, wen);
                end
                total++;
                if (bus_addr !== {addr[31:2], 2'b00}) begin
                    bad++; $display("FAIL bus_addr: got %h want %h", bus_addr, {addr[31:2], 2'b00});
                end
                if (wen) begin
                    total++;
                    if (bus_wdata !== wdata) begin
                        bad++; $display("FAIL bus_wdata: got %h want %h", bus_wdata, wdata);
                    end
                end
                if (k >= 0 && reqs == k) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end else begin
                    bus_rdata = $urandom;
                end
                reqs++;
            end
            #1;
            if (mem_stall) stalls++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        bus_ack = 1'b0;
        total++;
        if (!done) begin
            bad++; $display("FAIL stall_bound: stall still high after 64 cycles");
        end
        @(posedge clk); #1;
        if (!hold) mem_valid = 1'b0;

        if (bad_req || (good && !acked)) exp_err = 1'b1;
        if (acked && ren) exp_rdata = rd;

        total++;
        if (stalls != exp_stall) begin
            bad++; $display("FAIL stall_len: got %0d want %0d (addr %h k %0d)", stalls, exp_stall, addr, k);
        end
        total++;
        if (reqs != exp_reqs) begin
            bad++; $display("FAIL req_cycles: got %0d want %0d (addr %h k %0d)", reqs, exp_reqs, addr, k);
        end
        total++;
        if (mem_err !== exp_err) begin
            bad++; $display("FAIL mem_err: got %0b want %0b (addr %h)", mem_err, exp_err, addr);
        end
        total++;
        if (mem_rdata !== exp_rdata) begin
            bad++; $display("FAIL mem_rdata: got %h want %h", mem_rdata, exp_rdata);
        end
        total++;
        if (bus_req !== 1'b0) begin
            bad++; $display("FAIL bus_req_idle: got %0b want 0", bus_req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
        mem_addr = 32'h40; mem_wdata = 32'h1; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", mem_stall); end
        total++;
        if ({bus_req, bus_we, mem_err} !== 3'b000) begin
            bad++; $display("FAIL rst_flags: got %b want 000", {bus_req, bus_we, mem_err});
        end
        total++;
        if ({bus_addr, bus_wdata, mem_rdata} !== 96'h0) begin
            bad++; $display("FAIL rst_data: got %h %h %h want 0", bus_addr, bus_wdata, mem_rdata);
        end
        rst = 1'b0; mem_valid = 1'b0;
        exp_err = 1'b0; exp_rdata = '0;
    endtask

    task automatic test_invalid;
        run_access(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 0, 32'h11111111, 1'b0);
        run_access(1'b0, 1'b1, 1'b1, 32'h53, 32'h0, 0, 32'h22222222, 1'b0);
    endtask

    task automatic test_load;
        run_access(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_store;
        run_access(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 0, 32'h55AA55AA, 1'b0);
    endtask

    task automatic test_back_to_back;
        int r0;
        r0 = req_rises;
        run_access(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hA1A1A1A1, 1'b1);
        run_access(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 2, 32'hB2B2B2B2, 1'b0);
        total++;
        if (req_rises - r0 != 2) begin
            bad++; $display("FAIL b2b_pulses: got %0d want 2", req_rises - r0);
        end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, -1, 32'h0, 1'b0);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if (mem_stall !== 1'b0) begin bad++; $display("FAIL late_ack_stall: got %0b want 0", mem_stall); end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        total++;
        if (mem_rdata !== exp_rdata || bus_req !== 1'b0) begin
            bad++; $display("FAIL late_ack: got rdata %h req %0b want %h 0", mem_rdata, bus_req, exp_rdata);
        end
        run_access(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 2, 32'h0BADF00D, 1'b0);
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h33333333, 1'b0);
        run_access(1'b1, 1'b1, 1'b1, 32'h14, 32'h9, 0, 32'h44444444, 1'b0);
    endtask

    task automatic test_random;
        logic        v, r, w;
        logic [31:0] a;
        int          k;
        for (int i = 0; i < 16; i++) begin
            v = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            run_access(v, r, w, a, $urandom, k, $urandom, 1'b0);
        end
    endtask

    task automatic test_rst_mid;
        int n;
        @(negedge clk);
        mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h30;
        n = 0;
        while (!bus_req && n < 5) begin @(negedge clk); n++; end
        total++;
        if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %0b want 1", bus_req); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_err = 1'b0; exp_rdata = '0;
        total++;
        if ({bus_req, mem_stall, mem_err, bus_we} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_flags: got %b want 0000", {bus_req, mem_stall, mem_err, bus_we});
        end
        total++;
        if ({bus_addr, mem_rdata} !== 64'h0) begin
            bad++; $display("FAIL mid_rst_data: got %h %h want 0", bus_addr, mem_rdata);
        end
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFEEDFACE;
        #1;
        total++;
        if (mem_stall !== 1'b0) begin bad++; $display("FAIL stale_ack_stall: got %0b want 0", mem_stall); end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0 || mem_rdata !== exp_rdata) begin
            bad++; $display("FAIL stale_ack: got req %0b rdata %h want 0 %h", bus_req, mem_rdata, exp_rdata);
        end
        run_access(1'b1, 1'b0, 1'b1, 32'h60, 32'h77, 1, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_invalid();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_random();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
